// File: rtl/dino_jump_ctrl.sv
// dino_jump_ctrl
//   Jump/duck physics and leg animation for the runner sprite.
//   The internal state (RUN/DUCK/AIR), height h and velocity v advance only on
//   phys_tick while enable is high. Renderer-facing outputs are registered
//   copies, so they show new values one clk after the updating edge.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous active-high reset
//   phys_tick  in   one-clk pulse, advances one physics step
//   anim_tick  in   one-clk pulse, toggles the walk frame (RUN/DUCK only)
//   jump       in   debounced jump button (level, rising edge triggers)
//   duck       in   debounced duck button (level)
//   enable     in   game running; low freezes all state
//   dino_y     out  [31:0] foot-line Y = GROUND_Y - h
//   airborne   out  state is AIR
//   ducking    out  state is DUCK
//   leg_phase  out  walk sprite frame select
//   state      out  [1:0] RUN=0, DUCK=1, AIR=2
//
// Configuration macro
//   DINO_FAST_FALL_EN : when defined, holding duck in the air subtracts
//                       3*GRAVITY per tick instead of GRAVITY.
module dino_jump_ctrl #(
  parameter int GROUND_Y = 360,
  parameter int V0       = 12,
  parameter int GRAVITY  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        phys_tick,
  input  logic        anim_tick,
  input  logic        jump,
  input  logic        duck,
  input  logic        enable,
  output logic [31:0] dino_y,
  output logic        airborne,
  output logic        ducking,
  output logic        leg_phase,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_DUCK = 2'd1,
    ST_AIR  = 2'd2
  } state_t;

  localparam logic signed [9:0] V0_S   = 10'(V0);
  localparam logic signed [9:0] GRAV_S = 10'(GRAVITY);
`ifdef DINO_FAST_FALL_EN
  localparam logic signed [9:0] FAST_S = 10'(3 * GRAVITY);
`endif

  state_t             r_state;
  logic        [7:0]  r_h;
  logic signed [7:0]  r_v;
  logic               r_pending;
  logic               r_jump_prev;
  logic               r_leg;
  logic        [31:0] r_dino_y;
  logic               r_airborne;
  logic               r_ducking;
  logic        [1:0]  r_state_out;

  logic               w_step;
  logic               w_rise;
  logic signed [9:0]  w_dec;
  logic signed [9:0]  w_sum;
  logic signed [9:0]  w_v_air;
  logic signed [9:0]  w_v_launch;

  // Clamp a 10-bit signed velocity into the 8-bit register, floor at -128.
  function automatic logic [7:0] sat8(input logic signed [9:0] x);
    if (x < -10'sd128)
      return 8'h80;
    else
      return x[7:0];
  endfunction

  always_comb begin
    w_step = phys_tick & enable;
    w_rise = jump & ~r_jump_prev;
    w_dec  = GRAV_S;
`ifdef DINO_FAST_FALL_EN
    if (duck)
      w_dec = FAST_S;
`endif
    // h is zero-extended and v sign-extended so the landing test is a true
    // signed compare with no wrap.
    w_sum      = $signed({2'b00, r_h}) + $signed({{2{r_v[7]}}, r_v});
    w_v_air    = $signed({{2{r_v[7]}}, r_v}) - w_dec;
    // The launch tick already counts as the first airborne step, so it uses
    // the same (possibly fast-fall) decrement as later AIR ticks.
    w_v_launch = V0_S - w_dec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_h         <= 8'd0;
      r_v         <= 8'sd0;
      r_pending   <= 1'b0;
      r_jump_prev <= 1'b0;
      r_leg       <= 1'b0;
      r_dino_y    <= 32'(GROUND_Y);
      r_airborne  <= 1'b0;
      r_ducking   <= 1'b0;
      r_state_out <= ST_RUN;
    end else begin
      // Edge detect keeps running while frozen so a press is not lost.
      r_jump_prev <= jump;

      // Any step outside RUN, or a step in RUN that launches, consumes the
      // request; otherwise a new rising edge arms it.
      if (w_step && (r_state != ST_RUN || r_pending))
        r_pending <= 1'b0;
      else if (w_rise)
        r_pending <= 1'b1;

      if (w_step) begin
        case (r_state)
          ST_RUN: begin
            if (r_pending) begin
              r_state <= ST_AIR;
              r_h     <= V0[7:0];
              r_v     <= sat8(w_v_launch);
            end else if (duck) begin
              r_state <= ST_DUCK;
              r_h     <= 8'd0;
              r_v     <= 8'sd0;
            end
          end
          ST_DUCK: begin
            if (!duck)
              r_state <= ST_RUN;
          end
          ST_AIR: begin
            if (w_sum <= 10'sd0) begin
              r_h     <= 8'd0;
              r_v     <= 8'sd0;
              r_state <= duck ? ST_DUCK : ST_RUN;
            end else begin
              r_h <= (w_sum > 10'sd255) ? 8'd255 : w_sum[7:0];
              r_v <= sat8(w_v_air);
            end
          end
          default: r_state <= ST_RUN;
        endcase
      end

      if (anim_tick && enable && r_state != ST_AIR)
        r_leg <= ~r_leg;

      // Output stage samples the internal state, giving a one-clk lag.
      r_dino_y    <= 32'(GROUND_Y) - {24'd0, r_h};
      r_airborne  <= (r_state == ST_AIR);
      r_ducking   <= (r_state == ST_DUCK);
      r_state_out <= r_state;
    end
  end

  assign dino_y    = r_dino_y;
  assign airborne  = r_airborne;
  assign ducking   = r_ducking;
  assign leg_phase = r_leg;
  assign state     = r_state_out;

endmodule

// File: tb/tb_dino_jump_ctrl.sv
// Directed bench for dino_jump_ctrl. Stimulus tasks push expected responses
// into a scoreboard queue tagged with the cycle at which the registered
// outputs must show them; a negedge monitor pops and compares.
module tb_dino_jump_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        phys_tick = 1'b0;
  logic        anim_tick = 1'b0;
  logic        jump = 1'b0;
  logic        duck = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] dino_y;
  logic        airborne;
  logic        ducking;
  logic        leg_phase;
  logic [1:0]  state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  dino_jump_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .phys_tick (phys_tick),
    .anim_tick (anim_tick),
    .jump      (jump),
    .duck      (duck),
    .enable    (enable),
    .dino_y    (dino_y),
    .airborne  (airborne),
    .ducking   (ducking),
    .leg_phase (leg_phase),
    .state     (state)
  );

`ifdef DINO_FAST_FALL_EN
  localparam int LAND_DUCK = 9;
`else
  localparam int LAND_DUCK = 25;
`endif

  // Hand-computed heights after each tick of a normal jump (V0=12, g=1).
  int h_tab [0:24] = '{12, 23, 33, 42, 50, 57, 63, 68, 72, 75, 77, 78, 78,
                       77, 75, 72, 68, 63, 57, 50, 42, 33, 23, 12, 0};

  // kind 0: y/state/flags, kind 1: leg only, kind 2: everything
  typedef struct {
    int    cyc;
    int    kind;
    string name;
    int    y;
    int    st;
    int    leg;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  function automatic int fy(int i);
    return (i >= 1 && i <= 24) ? 360 - h_tab[i-1] : 360;
  endfunction

  function automatic int fst(int i);
    return (i >= 1 && i <= 24) ? 2 : 0;
  endfunction

  task automatic push(string nm, int lat, int kind, int y, int st, int leg);
    exp_t e;
    e.cyc  = cyc + lat;
    e.kind = kind;
    e.name = nm;
    e.y    = y;
    e.st   = st;
    e.leg  = leg;
    sb_q.push_back(e);
  endtask

  // One physics tick; outputs are checked two edges later, leg one edge later.
  task automatic ptick(string nm, bit chk, int y, int st, bit anim, int leg);
    @(negedge clk);
    phys_tick = 1'b1;
    anim_tick = anim;
    if (anim) push({nm, "_leg"}, 1, 1, 0, 0, leg);
    if (chk)  push(nm, 2, 0, y, st, 0);
    @(negedge clk);
    phys_tick = 1'b0;
    anim_tick = 1'b0;
  endtask

  task automatic atick(string nm, int leg);
    @(negedge clk);
    anim_tick = 1'b1;
    push(nm, 1, 1, 0, 0, leg);
    @(negedge clk);
    anim_tick = 1'b0;
  endtask

  task automatic jpulse();
    @(negedge clk);
    jump = 1'b1;
    @(negedge clk);
    jump = 1'b0;
  endtask

  // Monitor
  exp_t mon_e;
  logic mon_ok;
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mon_e = sb_q.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc) begin
        $display("FAIL %s: sample slot missed, now cycle %0d, required cycle %0d",
                 mon_e.name, cyc, mon_e.cyc);
      end else begin
        if (mon_e.kind == 1) begin
          mon_ok = (leg_phase == mon_e.leg[0]);
        end else begin
          mon_ok = (dino_y == 32'(mon_e.y)) && (state == mon_e.st[1:0]) &&
                   (airborne == (mon_e.st == 2)) && (ducking == (mon_e.st == 1));
          if (mon_e.kind == 2)
            mon_ok = mon_ok && (leg_phase == mon_e.leg[0]);
        end
        if (mon_ok) begin
          n_pass++;
          $display("ok   %-14s y=%0d st=%0d air=%0b duck=%0b leg=%0b",
                   mon_e.name, dino_y, state, airborne, ducking, leg_phase);
        end else begin
          $display("FAIL %s: got y=%0d st=%0d air=%0b duck=%0b leg=%0b, required y=%0d st=%0d leg=%0d (kind %0d)",
                   mon_e.name, dino_y, state, airborne, ducking, leg_phase,
                   mon_e.y, mon_e.st, mon_e.leg, mon_e.kind);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin
    // Reset values while rst is held
    @(negedge clk);
    push("rst_init", 1, 2, 360, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;

    // Basic jump, every tick checked; a press mid-flight must be discarded
    jpulse();
    for (int i = 1; i <= 25; i++) begin
      ptick($sformatf("jump_t%0d", i), 1'b1, fy(i), fst(i), 1'b0, 0);
      if (i == 10) jpulse();
    end
    ptick("no_rejump", 1'b1, 360, 0, 1'b0, 0);

    // Held jump: one flight only
    @(negedge clk);
    jump = 1'b1;
    for (int i = 1; i <= 60; i++) begin
      ptick($sformatf("held_t%0d", i),
            (i == 1 || i == 12 || i == 24 || i == 25 || i == 40 || i == 60),
            fy(i), fst(i), 1'b0, 0);
    end
    @(negedge clk);
    jump = 1'b0;
    jpulse();
    for (int i = 1; i <= 25; i++)
      ptick($sformatf("repress_t%0d", i), (i == 1 || i == 25), fy(i), fst(i), 1'b0, 0);

    // Duck and leg animation; tick+anim together in RUN
    atick("leg_run", 1);
    duck = 1'b1;
    ptick("duck_enter", 1'b1, 360, 1, 1'b1, 0);
    atick("leg_duck", 1);
    duck = 1'b0;
    ptick("duck_exit", 1'b1, 360, 0, 1'b0, 0);

    // Jump edge and duck together: jump wins, duck held at landing -> DUCK
    duck = 1'b1;
    jpulse();
    for (int i = 1; i <= LAND_DUCK; i++) begin
      if (i == 1)
        ptick("jd_t1", 1'b1, 348, 2, 1'b0, 0);
      else if (i == 2)
        ptick("jd_air", 1'b0, 0, 0, 1'b1, 1);
      else if (i == LAND_DUCK - 1)
        ptick("jd_prelanding", 1'b1, 348, 2, 1'b0, 0);
      else if (i == LAND_DUCK)
        ptick("jd_land", 1'b1, 360, 1, 1'b0, 0);
      else
        ptick("jd", 1'b0, 0, 0, 1'b0, 0);
    end
    duck = 1'b0;
    ptick("jd_exit", 1'b1, 360, 0, 1'b0, 0);

    // Freeze mid-flight at h=50
    jpulse();
    for (int i = 1; i <= 5; i++)
      ptick($sformatf("frz_pre_t%0d", i), (i == 5), 310, 2, 1'b0, 0);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 1; i <= 100; i++)
      ptick($sformatf("frz_t%0d", i), (i == 1 || i == 100), 310, 2, 1'b0, 0);
    atick("frz_leg", 1);

    // Asynchronous reset mid-flight, seen before any further clk edge
    @(posedge clk);
    #1;
    rst = 1'b1;
    push("rst_async", 0, 2, 360, 0, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Rising edge while frozen arms the jump
    enable = 1'b0;
    jpulse();
    @(negedge clk);
    enable = 1'b1;
    for (int i = 1; i <= 25; i++)
      ptick($sformatf("frzedge_t%0d", i), (i == 1 || i == 25), fy(i), fst(i), 1'b0, 0);

    // Drain
    for (int i = 0; i < 20; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      $display("FAIL drain: %0d expectations never sampled, required 0", sb_q.size());
      n_checks += sb_q.size();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
